// File: rtl/sens_pkg.sv
// Shared definitions for the multi-channel sensor stream hub: mode bit positions,
// default geometry and the FIFO entry layout {tag, data}.
package sens_pkg;

    localparam int SM_PDN    = 0;
    localparam int SM_LATEST = 1;
    localparam int SM_STREAM = 2;
    localparam int SM_IRQ    = 3;

    localparam int NCH_DEF   = 4;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 64;
    localparam int CHW_DEF   = 2;

    typedef struct packed {
        logic [CHW_DEF-1:0] tag;
        logic [DW_DEF-1:0]  data;
    } sens_entry_t;

endpackage

// File: rtl/sens_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the search pointer,
// then moves the pointer to the channel following the grant.
module sens_rr_arb #(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  gnt_idx
);

    logic [IW-1:0] ptr;

    always_comb begin
        int   c;
        logic found;
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        c       = 0;
        for (int k = 0; k < NCH; k++) begin
            c = (int'(ptr) + k) % NCH;
            if (!found && req[c]) begin
                found   = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = IW'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sens_stream_hub.sv
// Multi-channel sensor capture: per-channel latest registers, change detection and a
// round-robin merge of changed samples into one tagged FIFO with watermark/overflow IRQ.
module sens_stream_hub
    import sens_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int DW          = DW_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int AW          = 6,
    parameter int CHW         = CHW_DEF,
    parameter int CHANGE_ONLY = 1,
    parameter int WMARK       = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] sens_data_i,
    input  logic [NCH-1:0]    sens_val_i,
    input  logic [7:0]        sens_mode,
    input  logic [CHW-1:0]    rd_ch,
    input  logic              rd_en,
    input  logic              irq_clr,
    output logic [DW-1:0]     rd_data,
    output logic [CHW-1:0]    rd_tag,
    output logic [AW:0]       fifo_level,
    output logic              ovf,
    output logic [NCH-1:0]    lost,
    output logic              irq
);

    typedef struct packed {
        logic [CHW-1:0] tag;
        logic [DW-1:0]  data;
    } entry_t;

    logic pdn, latest_md, stream, gen_irq;
    logic unused_mode_rsvd;

    assign pdn              = sens_mode[SM_PDN];
    assign latest_md        = sens_mode[SM_LATEST];
    assign stream           = sens_mode[SM_STREAM];
    assign gen_irq          = sens_mode[SM_IRQ];
    assign unused_mode_rsvd = ^sens_mode[7:4];

    logic [DW-1:0]  smp    [NCH];
    logic [DW-1:0]  latest [NCH];
    logic [NCH-1:0] smp_vld, upd, pend, req, gnt;
    logic [CHW-1:0] gnt_idx;
    logic           grant;

    // Capture stage: register the raw sample; comparison happens one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_vld <= '0;
            for (int c = 0; c < NCH; c++) smp[c] <= '0;
        end else begin
            // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
            smp_vld <= pdn ? '0 : sens_val_i;
            for (int c = 0; c < NCH; c++) begin
                if (sens_val_i[c] && !pdn) smp[c] <= sens_data_i[c*DW +: DW];
            end
        end
    end

    always_comb begin
        upd = '0;
        for (int c = 0; c < NCH; c++) begin
            upd[c] = smp_vld[c] && !pdn && ((CHANGE_ONLY == 0) || (smp[c] != latest[c]));
        end
    end

    // A pending sample granted this cycle is safe; only an ungranted one is overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            lost <= '0;
            for (int c = 0; c < NCH; c++) latest[c] <= '0;
        end else begin
            pend <= pdn ? '0 : ((pend & ~gnt) | upd);
            lost <= (lost & ~{NCH{irq_clr}}) | (upd & pend & ~gnt);
            for (int c = 0; c < NCH; c++) begin
                if (upd[c]) latest[c] <= smp[c];
            end
        end
    end

    assign req   = pend & {NCH{!pdn}};
    assign grant = |gnt;

    sens_rr_arb #(
        .NCH (NCH),
        .IW  (CHW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    logic [AW:0] wr_ptr, rd_ptr;
    entry_t      mem [DEPTH];
    logic        full, empty, pop, push, drop;

    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = rd_en && stream && !latest_md && !pdn && !empty;
    assign push       = grant && stream && (!full || pop);
    assign drop       = grant && stream && full && !pop;

    // NOTE: storage has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{tag: gnt_idx, data: latest[gnt_idx]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
            rd_tag  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (!pdn) begin
                if (latest_md) begin
                    rd_data <= (int'(rd_ch) < NCH) ? latest[rd_ch] : '0;
                end else if (pop) begin
                    rd_data <= mem[rd_ptr[AW-1:0]].data;
                    rd_tag  <= mem[rd_ptr[AW-1:0]].tag;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            irq <= 1'b0;
        end else begin
            ovf <= drop || (ovf && !irq_clr);
            irq <= gen_irq && !pdn &&
                   ((fifo_level >= (AW+1)'(WMARK)) || ovf || (|lost));
        end
    end

endmodule

// File: tb/tb_sens_stream_hub.sv
// Self-checking bench for sens_stream_hub: table-driven capture sequence, directed
// corner cases and a randomized run against a queue-based reference model.
module tb_sens_stream_hub;

    localparam int NCH   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int WMARK = 48;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sens_data_i;
    logic [3:0]  sens_val_i;
    logic [7:0]  sens_mode;
    logic [1:0]  rd_ch;
    logic        rd_en;
    logic        irq_clr;
    logic [7:0]  rd_data;
    logic [1:0]  rd_tag;
    logic [6:0]  fifo_level;
    logic        ovf;
    logic [3:0]  lost;
    logic        irq;

    always #5 clk = ~clk;

    sens_stream_hub #(
        .NCH(4), .DW(8), .DEPTH(64), .AW(6), .CHW(2), .CHANGE_ONLY(1), .WMARK(48)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sens_data_i (sens_data_i),
        .sens_val_i  (sens_val_i),
        .sens_mode   (sens_mode),
        .rd_ch       (rd_ch),
        .rd_en       (rd_en),
        .irq_clr     (irq_clr),
        .rd_data     (rd_data),
        .rd_tag      (rd_tag),
        .fifo_level  (fifo_level),
        .ovf         (ovf),
        .lost        (lost),
        .irq         (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel arrays plus a queue holding tag*256+data entries.
    logic [7:0] m_smp [NCH];
    bit         m_sv  [NCH];
    logic [7:0] m_lat [NCH];
    bit         m_pend[NCH];
    bit         m_lost[NCH];
    bit         m_ovf;
    bit         m_irq;
    int         m_ptr;
    int         m_q[$];
    logic [7:0] m_rd_data;
    logic [1:0] m_rd_tag;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_smp[c] = 0; m_sv[c] = 0; m_lat[c] = 0; m_pend[c] = 0; m_lost[c] = 0;
        end
        m_ovf = 0; m_irq = 0; m_ptr = 0; m_rd_data = 0; m_rd_tag = 0;
        m_q.delete();
    endfunction

    function automatic void model_step();
        bit         pdn, lm, st, gi, pop, drop, any_lost;
        int         lvl, g, e;
        logic [7:0] lat_old [NCH];
        bit         pend_old[NCH];
        pdn = sens_mode[0]; lm = sens_mode[1]; st = sens_mode[2]; gi = sens_mode[3];
        lvl = m_q.size();
        lat_old = m_lat;
        pend_old = m_pend;
        any_lost = 0;
        for (int c = 0; c < NCH; c++) any_lost |= m_lost[c];
        m_irq = gi && !pdn && (lvl >= WMARK || m_ovf || any_lost);
        g = -1; pop = 0; drop = 0;
        if (irq_clr) for (int c = 0; c < NCH; c++) m_lost[c] = 0;
        if (!pdn) begin
            for (int k = 0; k < NCH; k++)
                if (g < 0 && pend_old[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
            pop = rd_en && st && !lm && lvl > 0;
            if (lm) m_rd_data = lat_old[rd_ch];
            else if (pop) begin
                e = m_q.pop_front();
                m_rd_data = 8'(e);
                m_rd_tag  = 2'(e >> 8);
            end
            if (g >= 0) begin
                m_ptr = (g + 1) % NCH;
                m_pend[g] = 0;
                if (st) begin
                    if (m_q.size() < DEPTH) m_q.push_back(g * 256 + int'(lat_old[g]));
                    else drop = 1;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (m_sv[c] && m_smp[c] != lat_old[c]) begin
                    if (pend_old[c] && c != g) m_lost[c] = 1;
                    m_lat[c]  = m_smp[c];
                    m_pend[c] = 1;
                end
            end
        end else begin
            for (int c = 0; c < NCH; c++) m_pend[c] = 0;
        end
        m_ovf = drop || (m_ovf && !irq_clr);
        for (int c = 0; c < NCH; c++) begin
            m_sv[c] = !pdn && sens_val_i[c];
            if (m_sv[c]) m_smp[c] = sens_data_i[c*DW +: DW];
        end
    endfunction

    task automatic cmp_all();
        logic [3:0] lv;
        for (int c = 0; c < NCH; c++) lv[c] = m_lost[c];
        check("m_rd_data", 32'(rd_data), 32'(m_rd_data));
        check("m_rd_tag", 32'(rd_tag), 32'(m_rd_tag));
        check("m_level", 32'(fifo_level), 32'(m_q.size()));
        check("m_ovf", 32'(ovf), 32'(m_ovf));
        check("m_lost", 32'(lost), 32'(lv));
        check("m_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic set_idle();
        sens_val_i = '0; rd_en = 1'b0; irq_clr = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pop_check(input string name, input logic [1:0] tag, input logic [7:0] data);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check({name, "_tag"}, 32'(rd_tag), 32'(tag));
        check({name, "_data"}, 32'(rd_data), 32'(data));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ch0..ch2 pend while ch3 receives two back-to-back samples.
    task automatic make_lost();
        sens_val_i = 4'hF; sens_data_i = 32'h3A32_3130;
        step();
        sens_val_i = 4'h8; sens_data_i = 32'h3B00_0000;
        step();
        sens_val_i = 4'h0;
        idle_steps(6);
    endtask

    typedef struct {
        logic [3:0] val;
        logic [7:0] d1;
        logic [7:0] mode;
        logic       rd;
        logic [1:0] ch;
        int         lvl;
        logic [7:0] data;
        logic [1:0] tag;
    } vec_t;

    vec_t tv[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{4'h2, 8'h11, 8'h04, 1'b0, 2'd0, 0, 8'h00, 2'd0};
        tv[1]  = '{4'h2, 8'h11, 8'h04, 1'b0, 2'd0, 0, 8'h00, 2'd0};
        tv[2]  = '{4'h2, 8'h22, 8'h04, 1'b0, 2'd0, 1, 8'h00, 2'd0};
        tv[3]  = '{4'h0, 8'h00, 8'h04, 1'b0, 2'd0, 1, 8'h00, 2'd0};
        tv[4]  = '{4'h0, 8'h00, 8'h04, 1'b0, 2'd0, 2, 8'h00, 2'd0};
        tv[5]  = '{4'h0, 8'h00, 8'h04, 1'b0, 2'd0, 2, 8'h00, 2'd0};
        tv[6]  = '{4'h0, 8'h00, 8'h04, 1'b1, 2'd0, 1, 8'h11, 2'd1};
        tv[7]  = '{4'h0, 8'h00, 8'h04, 1'b1, 2'd0, 0, 8'h22, 2'd1};
        tv[8]  = '{4'h0, 8'h00, 8'h04, 1'b1, 2'd0, 0, 8'h22, 2'd1};
        tv[9]  = '{4'h0, 8'h00, 8'h06, 1'b1, 2'd0, 0, 8'h00, 2'd1};
        tv[10] = '{4'h0, 8'h00, 8'h06, 1'b1, 2'd1, 0, 8'h22, 2'd1};

        sens_data_i = '0; sens_mode = 8'h04; rd_ch = '0;
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        check("rst_level", 32'(fifo_level), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_irq", 32'(irq), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Change-only capture, FIFO pops, empty read and LATEST reads.
        for (int i = 0; i < 11; i++) begin
            sens_val_i  = tv[i].val;
            sens_data_i = {16'h0, tv[i].d1, 8'h0};
            sens_mode   = tv[i].mode;
            rd_en       = tv[i].rd;
            rd_ch       = tv[i].ch;
            step();
            check($sformatf("tv%0d_level", i), 32'(fifo_level), 32'(tv[i].lvl));
            check($sformatf("tv%0d_data", i), 32'(rd_data), 32'(tv[i].data));
            check($sformatf("tv%0d_tag", i), 32'(rd_tag), 32'(tv[i].tag));
        end

        // Simultaneous valid on all channels, then round-robin continuation.
        sens_mode = 8'h04; rd_ch = '0;
        do_reset();
        sens_val_i = 4'hF; sens_data_i = 32'hA3A2_A1A0;
        step();
        sens_val_i = 4'h0;
        idle_steps(5);
        check("burst_level", 32'(fifo_level), 4);
        for (int i = 0; i < 4; i++)
            pop_check($sformatf("burst%0d", i), 2'(i), 8'hA0 + 8'(i));
        sens_val_i = 4'h1; sens_data_i = 32'h0000_00B0;
        step();
        sens_val_i = 4'h0;
        idle_steps(3);
        sens_val_i = 4'hF; sens_data_i = 32'hC3C2_C1C0;
        step();
        sens_val_i = 4'h0;
        idle_steps(5);
        check("rr_level", 32'(fifo_level), 5);
        pop_check("rr0", 2'd0, 8'hB0);
        pop_check("rr1", 2'd1, 8'hC1);
        pop_check("rr2", 2'd2, 8'hC2);
        pop_check("rr3", 2'd3, 8'hC3);
        pop_check("rr4", 2'd0, 8'hC0);

        // Fill past full, overflow, push+pop at full, watermark IRQ.
        sens_mode = 8'h0C;
        do_reset();
        for (int i = 1; i <= 65; i++) begin
            sens_val_i = 4'h1; sens_data_i = 32'(i);
            step();
        end
        sens_val_i = 4'h0;
        idle_steps(3);
        check("full_level", 32'(fifo_level), 64);
        check("full_ovf", 32'(ovf), 1);
        check("full_irq", 32'(irq), 1);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        check("clr_ovf", 32'(ovf), 0);
        step();
        check("clr_irq_level", 32'(irq), 1);
        sens_val_i = 4'h2; sens_data_i = 32'h0000_7700;
        step();
        sens_val_i = 4'h0;
        step();
        pop_check("fullpp", 2'd0, 8'd1);
        check("fullpp_level", 32'(fifo_level), 64);
        check("fullpp_ovf", 32'(ovf), 0);
        for (int i = 0; i < 17; i++) begin
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        check("drain_data", 32'(rd_data), 32'h12);
        check("drain_level", 32'(fifo_level), 47);
        idle_steps(2);
        check("drain_irq", 32'(irq), 0);

        // LATEST read does not pop.
        sens_mode = 8'h04;
        do_reset();
        sens_val_i = 4'h4; sens_data_i = 32'h005C_0000;
        step();
        sens_val_i = 4'h0;
        idle_steps(3);
        sens_mode = 8'h06; rd_ch = 2'd2; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("latest_data", 32'(rd_data), 32'h5C);
        check("latest_level", 32'(fifo_level), 1);

        // Overwritten pending sample.
        sens_mode = 8'h04; rd_ch = '0;
        do_reset();
        make_lost();
        check("lost_flags", 32'(lost), 32'h8);
        check("lost_level", 32'(fifo_level), 4);
        pop_check("lost0", 2'd0, 8'h30);
        pop_check("lost1", 2'd1, 8'h31);
        pop_check("lost2", 2'd2, 8'h32);
        pop_check("lost3", 2'd3, 8'h3B);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        check("lost_clr", 32'(lost), 0);

        // POWERDOWN freezes the FIFO and masks IRQ; async reset mid-burst.
        sens_mode = 8'h0C;
        do_reset();
        make_lost();
        check("pdn_pre_irq", 32'(irq), 1);
        sens_mode = 8'h0D; sens_val_i = 4'hF; sens_data_i = 32'h5555_5555; rd_en = 1'b1;
        idle_steps(4);
        check("pdn_level", 32'(fifo_level), 4);
        check("pdn_irq", 32'(irq), 0);
        check("pdn_lost", 32'(lost), 32'h8);
        sens_mode = 8'h0C;
        set_idle();
        idle_steps(4);
        check("pdn_exit_level", 32'(fifo_level), 4);
        pop_check("pdn_pop", 2'd0, 8'h30);
        sens_val_i = 4'hF; sens_data_i = 32'h4443_4241;
        step();
        sens_val_i = 4'h0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_level", 32'(fifo_level), 0);
        check("arst_rd_data", 32'(rd_data), 0);
        check("arst_rd_tag", 32'(rd_tag), 0);
        check("arst_lost", 32'(lost), 0);
        check("arst_irq", 32'(irq), 0);
        check("arst_ovf", 32'(ovf), 0);
        model_reset();
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run with phases of light, medium and heavy reading.
        for (int seg = 0; seg < 15; seg++) begin
            int rd_pct;
            int pdn_pct;
            rd_pct  = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 35 : 70);
            pdn_pct = (seg % 5 == 4) ? 20 : 1;
            for (int cyc = 0; cyc < 200; cyc++) begin
                sens_val_i = 4'($urandom_range(0, 15));
                for (int c = 0; c < NCH; c++) sens_data_i[c*DW +: DW] = 8'($urandom_range(0, 3));
                sens_mode[7:4] = 4'($urandom_range(0, 15));
                sens_mode[3]   = ($urandom_range(0, 9) != 0);
                sens_mode[2]   = ($urandom_range(0, 9) != 0);
                sens_mode[1]   = ($urandom_range(0, 19) == 0);
                sens_mode[0]   = ($urandom_range(0, 99) < pdn_pct);
                rd_ch   = 2'($urandom_range(0, 3));
                rd_en   = ($urandom_range(0, 99) < rd_pct);
                irq_clr = ($urandom_range(0, 49) == 0);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
